alu_seq_divider: RTL and testbench
==================================

// Module: alu_seq_divider
// PURPOSE
//   Multi-cycle restoring divider in the ALU datapath, directly upstream of the 64-bit Z register.
//   Takes two DATA_WIDTH operands and returns {remainder, quotient} as one 2*DATA_WIDTH word.
//   The Z register captures the word while done is high: upper half = HI, lower half = LO.
//   The control unit issues one start pulse and then waits for done.
// PARAMETERS
//   DATA_WIDTH  32  operand width; result width is 2*DATA_WIDTH
//   CNT_WIDTH   6   iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH
// PORTS
//   clock        in   1       single clock; all state updates on its rising edge
//   clear_n      in   1       synchronous, active-low reset
//   start        in   1       begin a division; sampled only in IDLE
//   signed_op    in   1       1 = two's-complement divide, 0 = unsigned divide
//   dividend     in   DW      dividend, sampled on the accepted start cycle
//   divisor      in   DW      divisor, sampled on the accepted start cycle
//   busy         out  1       high from the cycle after accept until done drops
//   done         out  1       one-cycle pulse; result is valid on this cycle
//   div_by_zero  out  1       set with done when divisor==0; held with result
//   result       out  2*DW    {remainder, quotient}; feeds Z register BusMuxOut
// BEHAVIOUR
//   Reset (clear_n==0 at a rising edge):
//     - state goes to IDLE; busy=0, done=0, div_by_zero=0, result=0, counter=0.
//     - Reset wins over every other input, including mid-operation; no done is produced.
//   States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     - IDLE: start==1 latches the operands and goes to RUN.
//       Latched values: |dividend|, |divisor|, the sign of the quotient and the sign of the dividend.
//       Magnitudes are taken only when signed_op=1.
//       If the divisor is 0, IDLE goes to FIX instead of RUN.
//     - RUN: exactly DATA_WIDTH iterations, one quotient bit per cycle, MSB first.
//       Each iteration:
//         - shift {partial remainder, dividend} left by 1;
//         - trial-subtract the divisor magnitude in DW+1 bits;
//         - if the trial is non-negative, keep the difference and set the quotient LSB to 1;
//           otherwise restore.
//       Leaves RUN when the counter reaches DATA_WIDTH-1.
//     - FIX: one cycle of sign correction, then the result register is loaded.
//       Quotient is negated if the quotient sign is set; remainder is negated if the dividend sign is set.
//       Remainder carries the dividend's sign (truncating division).
//       Divide-by-zero: quotient = all ones, remainder = original dividend, div_by_zero=1.
//     - DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start accepted at cycle 0 -> done high at cycle DATA_WIDTH+2 (34 at default).
//     - Divide-by-zero: done high at cycle 2.
//   result and div_by_zero hold their last values until the next accepted start.
//     - On accept, div_by_zero clears; result keeps its old value until FIX.
//   start while busy (RUN, FIX or DONE) is ignored; operand inputs are don't-care after accept.
//     - start in the same cycle as done is ignored; the earliest new accept is the IDLE cycle after.
//   Overflow: signed 0x80000000 / -1 gives quotient 0x80000000 (wraps) and remainder 0; no flag.
//   Unsigned arithmetic is full DW-bit magnitude; 0 / x gives Q=0, R=0.
// TESTING
//   1. Unsigned 100/7 -> result=64'h00000002_0000000E, done at cycle 34, busy cycles 1..34.
//   2. Signed -7/2 -> Q=32'hFFFFFFFD, R=32'hFFFFFFFF; signed 7/-2 -> Q=32'hFFFFFFFD, R=32'h00000001.
//   3. 5/0 (either mode) -> Q=32'hFFFFFFFF, R=32'h5, div_by_zero=1, done at cycle 2.
//   4. Signed 32'h80000000 / 32'hFFFFFFFF -> result=64'h00000000_80000000, div_by_zero=0.
//      Unsigned same operands -> Q=0, R=32'h80000000.
//   5. Start 100/7, then pulse start with 9/3 at cycle 10 -> ignored; result stays 14 r 2.
//      Next start after done gives Q=3, R=0.
//   6. clear_n=0 at RUN cycle 5 -> next cycle busy=0, result=0, no done pulse.
//      A fresh start 50/5 then completes normally with Q=10, R=0.

Source files
------------

// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring divider feeding the Z register: returns {remainder, quotient}.
// Signed mode divides magnitudes, then fixes signs so that division truncates toward zero.
module alu_seq_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic                    signed_op,
  input  logic [DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dvs;
  logic                  q_neg;
  logic                  r_neg;
  logic                  zero_div;

  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;

  assign a_neg   = signed_op & dividend[DATA_WIDTH-1];
  assign b_neg   = signed_op & divisor[DATA_WIDTH-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            count       <= '0;
            q_neg       <= a_neg ^ b_neg;
            r_neg       <= a_neg;
            dvs         <= b_mag;
            // A zero divisor skips iteration; rem/quo are preloaded with the final answer
            if (divisor == '0) begin
              zero_div <= 1'b1;
              rem      <= dividend;
              quo      <= '1;
              state    <= FIX;
            end else begin
              zero_div <= 1'b0;
              rem      <= '0;
              quo      <= a_mag;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[DATA_WIDTH]) begin
            rem <= trial[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b0};
          end
          if (count == CNT_WIDTH'(DATA_WIDTH - 1)) begin
            state <= FIX;
          end else begin
            count <= count + CNT_WIDTH'(1);
          end
        end
        FIX: begin
          if (zero_div) begin
            result      <= {rem, quo};
            div_by_zero <= 1'b1;
          end else begin
            result <= {(r_neg ? -rem : rem), (q_neg ? -quo : quo)};
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: directed vectors plus random operations
// compared against a plain-arithmetic division model.
module tb_alu_seq_divider;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  int          checks;
  int          errors;
  logic [63:0] model_result;

  alu_seq_divider #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .result     (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {div_by_zero, remainder, quotient}; longint keeps -2^31 / -1 from overflowing
  function automatic logic [64:0] refDiv(input logic sop, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] ua, ub;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sop) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    ua = a / b;
    ub = a % b;
    return {1'b0, ub, ua};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation; inject_cyc >= 1 drives an extra start mid-operation that must be ignored
  task automatic applyStimulus(input logic sop, input logic [31:0] a, input logic [31:0] b,
                               input int inject_cyc, input logic [31:0] ia, input logic [31:0] ib);
    logic [64:0] expv;
    int          cyc;
    int          busy_cnt;
    int          lat;
    expv = refDiv(sop, a, b);
    lat  = expv[64] ? 2 : 34;
    @(negedge clock);
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    cyc      = 1;
    busy_cnt = 0;
    checkOutput("result_kept_on_accept", result, model_result);
    checkOutput("dbz_cleared_on_accept", {63'd0, div_by_zero}, 64'd0);
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      if (cyc == inject_cyc) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    if (busy) busy_cnt++;
    checkOutput("done_cycle", 64'(cyc), 64'(lat));
    checkOutput("busy_cycles", 64'(busy_cnt), 64'(lat));
    checkOutput("result", result, expv[63:0]);
    checkOutput("div_by_zero", {63'd0, div_by_zero}, {63'd0, expv[64]});
    // start during the done cycle must not be accepted
    start     = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
    checkOutput("idle_after_done", {63'd0, busy}, 64'd0);
    checkOutput("result_held", result, expv[63:0]);
    checkOutput("dbz_held", {63'd0, div_by_zero}, {63'd0, expv[64]});
    model_result = expv[63:0];
  endtask

  initial begin
    int seen;
    int sel;
    logic [31:0] ra, rb;
    checks       = 0;
    errors       = 0;
    model_result = 64'd0;
    clear_n      = 1'b0;
    start        = 1'b0;
    signed_op    = 1'b0;
    dividend     = 32'd0;
    divisor      = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    clear_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(1'b0, 32'd100, 32'd7, -1, 32'd0, 32'd0);
    checkOutput("t1_100_div_7", result, 64'h00000002_0000000E);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 32'd0, 32'd0);
    checkOutput("t2_neg7_div_2", result, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 32'd0, 32'd0);
    checkOutput("t2_7_div_neg2", result, 64'h00000001_FFFFFFFD);
    applyStimulus(1'b0, 32'd5, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("t3_unsigned_div0", result, 64'h00000005_FFFFFFFF);
    applyStimulus(1'b1, 32'd5, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("t3_signed_div0", result, 64'h00000005_FFFFFFFF);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0, 32'd0);
    checkOutput("t4_signed_overflow", result, 64'h00000000_80000000);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0, 32'd0);
    checkOutput("t4_unsigned_same", result, 64'h80000000_00000000);
    applyStimulus(1'b0, 32'd100, 32'd7, 10, 32'd9, 32'd3);
    checkOutput("t5_start_ignored", result, 64'h00000002_0000000E);
    applyStimulus(1'b0, 32'd9, 32'd3, -1, 32'd0, 32'd0);
    checkOutput("t5_next_start", result, 64'h00000000_00000003);
    applyStimulus(1'b0, 32'd0, 32'd13, -1, 32'd0, 32'd0);

    $display("[TB] reset during RUN");
    @(negedge clock);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    clear_n = 1'b0;
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    checkOutput("midrun_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrun_reset_result", result, 64'd0);
    checkOutput("midrun_reset_done", {63'd0, done}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    checkOutput("no_done_after_reset", 64'(seen), 64'd0);
    model_result = 64'd0;
    applyStimulus(1'b0, 32'd50, 32'd5, -1, 32'd0, 32'd0);
    checkOutput("t6_after_reset", result, 64'h00000000_0000000A);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel <= 3) rb = $urandom_range(1, 20);
      else if (sel == 4) rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
      else if (sel == 5) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      applyStimulus(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 3) == 0 ? 5 : -1,
                    $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
